// File: rtl/ra_builder.sv
// Region Array builder: after a start pulse, writes one Region Array entry per tile
// (control word plus Object List pointers) and can optionally seed each OPB head with an EOL word.
module ra_builder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] REGION_BASE,
    input  logic [31:0] OL_BASE,
    input  logic [31:0] FPU_PARAM_CFG,
    input  logic [31:0] TA_ALLOC_CTRL,
    input  logic [5:0]  tile_x_max,
    input  logic [5:0]  tile_y_max,
    input  logic        z_keep,
    input  logic        no_flush,
    input  logic        init_ol,
    input  logic        vram_wait,
    output logic        ra_vram_wr,
    output logic [23:0] ra_vram_addr,
    output logic [31:0] ra_vram_dout,
    output logic        busy,
    output logic        done,
    output logic [11:0] tiles_written
);
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned NT = 5;
    localparam int unsigned TW = 12;
    localparam logic [2:0]  IDX_NONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WR_CTRL, S_WR_PTR, S_WR_EOL, S_ADV, S_FIN
    } state_t;

    state_t                 state, state_d;
    logic [2:0]             idx, idx_d;
    logic [AW-1:0]          entry, entry_d;
    logic [5:0]             tile_x, tile_y, x_d, y_d;
    logic [NT-1:0][AW-1:0]  ptr, ptr_d;
    logic [TW-1:0]          tw_d;
    logic                   busy_d, done_d, wr_d;
    logic [AW-1:0]          addr_d;
    logic [DW-1:0]          dout_d;
    logic [2:0]             nxt;

    logic                   v2_q, z_keep_q, no_flush_q, init_ol_q;
    logic [NT-1:0][1:0]     n_q;
    logic [5:0]             x_max_q, y_max_q;

    logic [NT-1:0]          en;
    logic [12:0]            num_tiles;
    logic [2:0]             last_ptr;
    logic                   last_tile;
    logic                   unused_bits;

    assign unused_bits = ^{REGION_BASE[31:24], REGION_BASE[1:0], OL_BASE[31:24], OL_BASE[1:0],
                           FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0], TA_ALLOC_CTRL[31:18],
                           TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                           TA_ALLOC_CTRL[3:2]};

    // PT only exists in the six-word entry format
    assign en        = {(n_q[4] != 2'd0) && v2_q, n_q[3] != 2'd0, n_q[2] != 2'd0,
                        n_q[1] != 2'd0, n_q[0] != 2'd0};
    assign num_tiles = (13'(x_max_q) + 13'd1) * (13'(y_max_q) + 13'd1);
    assign last_ptr  = v2_q ? 3'd4 : 3'd3;
    assign last_tile = (tile_x == x_max_q) && (tile_y == y_max_q);

    function automatic logic [2:0] first_en(input logic [2:0] from, input logic [NT-1:0] mask);
        logic [2:0] r;
        r = IDX_NONE;
        for (int i = int'(NT) - 1; i >= 0; i--) begin
            if ((3'(i) >= from) && mask[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] ctrl_word(input logic [5:0] x, input logic [5:0] y,
                                                input logic last, input logic zk, input logic nf);
        return {last, zk, 1'b0, nf, 14'd0, y, x, 2'b00};
    endfunction

    // Run configuration, frozen on an accepted start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v2_q       <= 1'b0;
            n_q        <= '0;
            x_max_q    <= '0;
            y_max_q    <= '0;
            z_keep_q   <= 1'b0;
            no_flush_q <= 1'b0;
            init_ol_q  <= 1'b0;
        end else if (state == S_IDLE && start) begin
            v2_q       <= FPU_PARAM_CFG[21];
            n_q        <= {TA_ALLOC_CTRL[17:16], TA_ALLOC_CTRL[13:12], TA_ALLOC_CTRL[9:8],
                           TA_ALLOC_CTRL[5:4], TA_ALLOC_CTRL[1:0]};
            x_max_q    <= tile_x_max;
            y_max_q    <= tile_y_max;
            z_keep_q   <= z_keep;
            no_flush_q <= no_flush;
            init_ol_q  <= init_ol;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            entry         <= '0;
            tile_x        <= '0;
            tile_y        <= '0;
            ptr           <= '0;
            tiles_written <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ra_vram_wr    <= 1'b0;
            ra_vram_addr  <= '0;
            ra_vram_dout  <= '0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            entry         <= entry_d;
            tile_x        <= x_d;
            tile_y        <= y_d;
            ptr           <= ptr_d;
            tiles_written <= tw_d;
            busy          <= busy_d;
            done          <= done_d;
            ra_vram_wr    <= wr_d;
            ra_vram_addr  <= addr_d;
            ra_vram_dout  <= dout_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        entry_d = entry;
        x_d     = tile_x;
        y_d     = tile_y;
        ptr_d   = ptr;
        tw_d    = tiles_written;
        busy_d  = busy;
        done_d  = 1'b0;
        wr_d    = ra_vram_wr;
        addr_d  = ra_vram_addr;
        dout_d  = ra_vram_dout;
        nxt     = IDX_NONE;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETUP;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    tw_d     = '0;
                    entry_d  = {REGION_BASE[23:2], 2'b00};
                    x_d      = '0;
                    y_d      = '0;
                    ptr_d[0] = {OL_BASE[23:2], 2'b00};
                end
            end
            // One type per cycle: the next list region follows this type's whole allocation
            S_SETUP: begin
                if (idx == 3'(NT - 1)) begin
                    state_d = S_WR_CTRL;
                    idx_d   = '0;
                end else begin
                    ptr_d[idx + 3'd1] = ptr[idx] +
                        (en[idx] ? (AW'(num_tiles) << (3'd4 + 3'(n_q[idx]))) : AW'(0));
                    idx_d = idx + 3'd1;
                end
            end
            S_WR_CTRL: begin
                if (!vram_wait) begin
                    state_d = S_WR_PTR;
                    idx_d   = '0;
                end
            end
            S_WR_PTR: begin
                if (!vram_wait) begin
                    if (idx == last_ptr) begin
                        nxt = first_en(3'd0, en);
                        if (init_ol_q && nxt != IDX_NONE) begin
                            state_d = S_WR_EOL;
                            idx_d   = nxt;
                        end else begin
                            state_d = S_ADV;
                        end
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            S_WR_EOL: begin
                if (!vram_wait) begin
                    nxt = first_en(idx + 3'd1, en);
                    if (nxt == IDX_NONE) state_d = S_ADV;
                    else                 idx_d   = nxt;
                end
            end
            S_ADV: begin
                for (int t = 0; t < int'(NT); t++) begin
                    if (en[t]) ptr_d[t] = ptr[t] + (AW'(16) << n_q[t]);
                end
                entry_d = entry + (v2_q ? AW'(24) : AW'(20));
                tw_d    = tiles_written + 12'd1;
                if (last_tile) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WR_CTRL;
                    if (tile_x == x_max_q) begin
                        x_d = '0;
                        y_d = tile_y + 6'd1;
                    end else begin
                        x_d = tile_x + 6'd1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Write port presents the word belonging to the state being entered; frozen while stalled
        if (!ra_vram_wr || !vram_wait) begin
            case (state_d)
                S_WR_CTRL: begin
                    wr_d   = 1'b1;
                    addr_d = entry_d;
                    dout_d = ctrl_word(x_d, y_d, (x_d == x_max_q) && (y_d == y_max_q),
                                       z_keep_q, no_flush_q);
                end
                S_WR_PTR: begin
                    wr_d   = 1'b1;
                    addr_d = entry + ((AW'(idx_d) + AW'(1)) << 2);
                    dout_d = en[idx_d] ? {8'h00, ptr[idx_d]} : 32'h8000_0000;
                end
                S_WR_EOL: begin
                    wr_d   = 1'b1;
                    addr_d = ptr[idx_d];
                    dout_d = 32'hF000_0000;
                end
                default: wr_d = 1'b0;
            endcase
        end
    end

endmodule
